// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake between the register side and the scan controller
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  ld_valid;
  logic [4*DIGITS-1:0]   ld_data;
  logic                  ld_ready;
  modport master(output ld_valid, ld_data, input ld_ready);
  modport slave(input ld_valid, ld_data, output ld_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous double-buffered loads; SEG_SCAN_DIM_EN adds dim duty control
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL = 1024,
  parameter int BLANK = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]        dim,
`endif
  seg_scan_ctrl_if.slave    ld,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_tick
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX);
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  state_t              state;
  logic [4*DIGITS-1:0] shadow, pend;
  logic                pend_v;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt, cnt_inc;
  logic                last_show, commit;
  logic [6:0]          pat, pat_first, pat_next;
  assign ld.ld_ready = !pend_v;
  assign cnt_inc = cnt + CW'(1);
  assign last_show = en && state == S_SHOW && cnt == CW'(DWELL - 1) && idx == IW'(DIGITS - 1);
  assign commit = pend_v && (state == S_IDLE || last_show);
  assign pat = HEX7[shadow[{idx, 2'b00} +: 4]];
`ifdef SEG_SCAN_DIM_EN
  logic [2:0] dim_q;
  assign pat_first = dim_q == 3'd0 ? pat : '0;
  assign pat_next = 32'(cnt_inc) % 32'd8 >= 32'(dim_q) ? pat : '0;
  // dim level follows the displayed value so brightness changes never tear mid-frame
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) dim_q <= 3'd0;
    else if (state == S_IDLE || commit) dim_q <= dim;
`else
  assign pat_first = pat;
  assign pat_next = pat;
`endif
  // accept into the pending slot; move it to the displayed buffer while idle or at frame end
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) begin
      shadow <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (commit) begin
      shadow <= pend;
      pend_v <= 1'b0;
    end else if (ld.ld_valid && !pend_v) begin
      pend   <= ld.ld_data;
      pend_v <= 1'b1;
    end
  // scan sequencer: blank gap then dwell per digit, outputs registered with the state
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      seg_out    <= '0;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en || state == S_IDLE) begin
        state   <= en ? S_BLANK : S_IDLE;
        idx     <= '0;
        cnt     <= '0;
        seg_out <= '0;
        dig_en  <= '0;
      end else if (state == S_BLANK) begin
        if (cnt == CW'(BLANK - 1)) begin
          state   <= S_SHOW;
          cnt     <= '0;
          dig_en  <= DIGITS'(1) << idx;
          seg_out <= pat_first;
        end else cnt <= cnt_inc;
      end else if (cnt == CW'(DWELL - 1)) begin
        state      <= S_BLANK;
        cnt        <= '0;
        dig_en     <= '0;
        seg_out    <= '0;
        idx        <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
        frame_tick <= idx == IW'(DIGITS - 1);
      end else begin
        cnt     <= cnt_inc;
        seg_out <= pat_next;
      end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plan plus random loads/enables checked against a time-arithmetic display model
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4, DWELL = 8, BLANK = 2;
  localparam int SLOT = BLANK + DWELL, FRAME = DIGITS * SLOT;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [2:0] dim = 3'd0;
  logic [6:0] seg_out;
  logic [DIGITS-1:0] dig_en;
  logic frame_tick;
  int n_chk = 0, n_fail = 0;
  const logic [6:0] hexp [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic m_idle = 1'b1, m_pendv = 1'b0;
  int j = 0;
  logic [15:0] m_shadow = '0, m_pend = '0;
  logic [2:0] m_dim = '0;
  always #5 clk = ~clk;
  seg_scan_ctrl_if #(.DIGITS(DIGITS)) ld();
  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .en(en),
`ifdef SEG_SCAN_DIM_EN
    .dim(dim),
`endif
    .ld(ld),
    .seg_out(seg_out),
    .dig_en(dig_en),
    .frame_tick(frame_tick)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    logic old_idle, acc, cm, lit;
    int ph, d, c;
    logic [6:0] es;
    logic [DIGITS-1:0] ed;
    logic et;
    @(posedge clk);
    if (!rst_n) begin
      m_idle = 1'b1; j = 0; m_shadow = '0; m_pend = '0; m_pendv = 1'b0; m_dim = '0;
    end else begin
      old_idle = m_idle;
      acc = ld.ld_valid && !m_pendv;
      if (!en) begin m_idle = 1'b1; j = 0; end
      else if (m_idle) begin m_idle = 1'b0; j = 0; end
      else j++;
      cm = m_pendv && (old_idle || (!m_idle && !old_idle && j % FRAME == 0));
      if (old_idle || cm) m_dim = dim;
      if (cm) begin m_shadow = m_pend; m_pendv = 1'b0; end
      else if (acc) begin m_pend = ld.ld_data; m_pendv = 1'b1; end
    end
    #1;
    ph = j % SLOT;
    d = (j / SLOT) % DIGITS;
    c = ph - BLANK;
    lit = !m_idle && ph >= BLANK;
    ed = lit ? DIGITS'(1 << d) : '0;
    es = (lit && c % 8 >= int'(m_dim)) ? hexp[m_shadow[4*d +: 4]] : 7'd0;
    et = !m_idle && j > 0 && j % FRAME == 0;
    chk("seg_out", 32'(seg_out), 32'(es));
    chk("dig_en", 32'(dig_en), 32'(ed));
    chk("frame_tick", 32'(frame_tick), 32'(et));
    chk("ld_ready", 32'(ld.ld_ready), 32'(!m_pendv));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    ld.ld_valid = 1'b1;
    ld.ld_data = 16'hBEEF;
    en = 1'b1;
    run(2);
    rst_n = 1'b1;
    en = 1'b0;
    ld.ld_valid = 1'b0;
    tick();
    ld.ld_valid = 1'b1;
    ld.ld_data = 16'h1234;
    tick();
    ld.ld_valid = 1'b0;
    tick();
    en = 1'b1;
    run(2 * FRAME + 5);
    for (int i = 0; i < 2 * FRAME && (j % FRAME) != 15; i++) tick();
    ld.ld_valid = 1'b1;
    ld.ld_data = 16'hFFFF;
    run(2 * FRAME + 10);
    ld.ld_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME && !(!m_idle && j % SLOT >= BLANK && (j / SLOT) % DIGITS == 2); i++) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    run(FRAME + 5);
    for (int i = 0; i < 2 * FRAME && !(!m_idle && j % SLOT >= BLANK && (j / SLOT) % DIGITS == 1); i++) tick();
    ld.ld_valid = 1'b1;
    ld.ld_data = 16'hABCD;
    tick();
    ld.ld_valid = 1'b0;
    run(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(FRAME + 5);
`ifdef SEG_SCAN_DIM_EN
    dim = 3'd4;
    en = 1'b0;
    tick();
    en = 1'b1;
    run(FRAME + 5);
    dim = 3'd0;
`endif
    for (int i = 0; i < 2000; i++) begin
      en = $urandom_range(0, 99) != 0;
      rst_n = $urandom_range(0, 499) != 0;
      ld.ld_valid = $urandom_range(0, 7) == 0;
      ld.ld_data = 16'($urandom);
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(0, 63) == 0) dim = 3'($urandom);
`endif
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
